// File: rtl/mm_addr_seq.sv
// Loop-nest address sequencer for the MM engine: walks N x Co x Ci, issues buffer reads and delayed output writes.
// Optional feature macro: MM_PERF_CNT_EN adds the perf_cycles stall-cycle counter port.
module mm_addr_seq #(
    parameter int IN_AW   = 11,
    parameter int W_AW    = 13,
    parameter int OUT_AW  = 11,
    parameter int CI_W    = 8,
    parameter int N_W     = 16,
    parameter int OUT_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IN_AW-1:0]  in_base,
    input  logic [W_AW-1:0]   w_base,
    input  logic [OUT_AW-1:0] out_base,
    input  logic [CI_W-1:0]   ci_num,
    input  logic [CI_W-1:0]   co_num,
    input  logic [N_W-1:0]    n_num,
    input  logic              stall,
    output logic              rd_valid,
    output logic [IN_AW-1:0]  rd_in_addr,
    output logic [W_AW-1:0]   rd_w_addr,
    output logic              rd_last,
    output logic              wr_valid,
    output logic [OUT_AW-1:0] wr_addr,
    output logic              busy,
    output logic              done
`ifdef MM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [OUT_LAT-1:0] LAST_ONLY = OUT_LAT'(1) << (OUT_LAT - 1);

    state_t              state_q, state_d;
    logic [CI_W-1:0]     ciNum_q, ciNum_d, coNum_q, coNum_d;
    logic [N_W-1:0]      nNum_q, nNum_d;
    logic [CI_W-1:0]     ciCnt_q, ciCnt_d, coCnt_q, coCnt_d;
    logic [N_W-1:0]      nCnt_q, nCnt_d;
    logic [W_AW-1:0]     wBase_q, wBase_d;
    logic [IN_AW-1:0]    inRow_q, inRow_d;
    logic [W_AW-1:0]     wRow_q, wRow_d;
    logic [OUT_AW-1:0]   wrNext_q, wrNext_d, wrAddr_q, wrAddr_d;
    logic [OUT_LAT-1:0]  pipe_q, pipe_d;
    logic                rdValid_q, rdValid_d, rdLast_q, rdLast_d;
    logic [IN_AW-1:0]    rdInAddr_q, rdInAddr_d;
    logic [W_AW-1:0]     rdWAddr_q, rdWAddr_d;

    logic                idle, accept, zeroCfg, issue, pipeIn;
    logic                lastCi, lastCo, lastN;
    logic [OUT_LAT:0]    shifted;
    logic [CI_W-1:0]     curCiNum, curCoNum, curCi, curCo;
    logic [N_W-1:0]      curNNum, curN;
    logic [IN_AW-1:0]    curInRow;
    logic [W_AW-1:0]     curWRow, curWBase;

    // In IDLE the first beat is built straight from the ports so it lands the cycle after start.
    always_comb begin
        idle     = (state_q == IDLE);
        curCiNum = idle ? ci_num   : ciNum_q;
        curCoNum = idle ? co_num   : coNum_q;
        curNNum  = idle ? n_num    : nNum_q;
        curCi    = idle ? '0       : ciCnt_q;
        curCo    = idle ? '0       : coCnt_q;
        curN     = idle ? '0       : nCnt_q;
        curInRow = idle ? in_base  : inRow_q;
        curWRow  = idle ? w_base   : wRow_q;
        curWBase = idle ? w_base   : wBase_q;

        zeroCfg = (curCiNum == '0) || (curCoNum == '0) || (curNNum == '0);
        accept  = idle && start;
        issue   = (accept && !zeroCfg) || ((state_q == RUN) && !stall);
        lastCi  = (curCi == curCiNum - CI_W'(1));
        lastCo  = (curCo == curCoNum - CI_W'(1));
        lastN   = (curN  == curNNum  - N_W'(1));

        pipeIn  = rdValid_q && rdLast_q;
        shifted = {pipe_q, pipeIn};
        pipe_d  = shifted[OUT_LAT-1:0];

        state_d    = state_q;
        ciNum_d    = ciNum_q;
        coNum_d    = coNum_q;
        nNum_d     = nNum_q;
        wBase_d    = wBase_q;
        ciCnt_d    = ciCnt_q;
        coCnt_d    = coCnt_q;
        nCnt_d     = nCnt_q;
        inRow_d    = inRow_q;
        wRow_d     = wRow_q;
        wrNext_d   = wrNext_q;
        wrAddr_d   = wrAddr_q;
        rdValid_d  = 1'b0;
        rdLast_d   = 1'b0;
        rdInAddr_d = rdInAddr_q;
        rdWAddr_d  = rdWAddr_q;

        if (shifted[OUT_LAT-1]) begin
            wrAddr_d = wrNext_q;
            wrNext_d = wrNext_q + OUT_AW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    ciNum_d  = ci_num;
                    coNum_d  = co_num;
                    nNum_d   = n_num;
                    wBase_d  = w_base;
                    wrNext_d = out_base;
                    state_d  = zeroCfg ? DONE : RUN;
                end
            end
            RUN: ;
            // Finished once the only pending write is the one on the output and nothing new is entering.
            DRAIN: begin
                if ((pipe_q == LAST_ONLY) && !pipeIn) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (issue) begin
            rdValid_d  = 1'b1;
            rdLast_d   = lastCi;
            rdInAddr_d = curInRow + IN_AW'(curCi);
            rdWAddr_d  = curWRow + W_AW'(curCi);
            ciCnt_d    = curCi + CI_W'(1);
            coCnt_d    = curCo;
            nCnt_d     = curN;
            inRow_d    = curInRow;
            wRow_d     = curWRow;
            if (lastCi) begin
                ciCnt_d = '0;
                if (!lastCo) begin
                    coCnt_d = curCo + CI_W'(1);
                    wRow_d  = curWRow + W_AW'(curCiNum);
                end else begin
                    coCnt_d = '0;
                    nCnt_d  = curN + N_W'(1);
                    wRow_d  = curWBase;
                    inRow_d = curInRow + IN_AW'(curCiNum);
                    if (lastN) begin
                        state_d = DRAIN;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ciNum_q    <= '0;
            coNum_q    <= '0;
            nNum_q     <= '0;
            wBase_q    <= '0;
            ciCnt_q    <= '0;
            coCnt_q    <= '0;
            nCnt_q     <= '0;
            inRow_q    <= '0;
            wRow_q     <= '0;
            wrNext_q   <= '0;
            wrAddr_q   <= '0;
            pipe_q     <= '0;
            rdValid_q  <= 1'b0;
            rdLast_q   <= 1'b0;
            rdInAddr_q <= '0;
            rdWAddr_q  <= '0;
        end else begin
            state_q    <= state_d;
            ciNum_q    <= ciNum_d;
            coNum_q    <= coNum_d;
            nNum_q     <= nNum_d;
            wBase_q    <= wBase_d;
            ciCnt_q    <= ciCnt_d;
            coCnt_q    <= coCnt_d;
            nCnt_q     <= nCnt_d;
            inRow_q    <= inRow_d;
            wRow_q     <= wRow_d;
            wrNext_q   <= wrNext_d;
            wrAddr_q   <= wrAddr_d;
            pipe_q     <= pipe_d;
            rdValid_q  <= rdValid_d;
            rdLast_q   <= rdLast_d;
            rdInAddr_q <= rdInAddr_d;
            rdWAddr_q  <= rdWAddr_d;
        end
    end

    assign rd_valid   = rdValid_q;
    assign rd_last    = rdLast_q;
    assign rd_in_addr = rdInAddr_q;
    assign rd_w_addr  = rdWAddr_q;
    assign wr_valid   = pipe_q[OUT_LAT-1];
    assign wr_addr    = wrAddr_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

`ifdef MM_PERF_CNT_EN
    logic [31:0] perf_q;

    // Stall cycles while busy; cleared by an accepted start and held after completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (busy && stall) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mm_addr_seq.sv
// Directed testbench for mm_addr_seq; samples on the falling edge, one task per scenario.
module tb_mm_addr_seq;

    localparam int IN_AW   = 11;
    localparam int W_AW    = 13;
    localparam int OUT_AW  = 11;
    localparam int CI_W    = 8;
    localparam int N_W     = 16;
    localparam int OUT_LAT = 4;

    logic              clk = 1'b0;
    logic              rst, start, stall;
    logic [IN_AW-1:0]  inBase;
    logic [W_AW-1:0]   wBase;
    logic [OUT_AW-1:0] outBase;
    logic [CI_W-1:0]   ciNum, coNum;
    logic [N_W-1:0]    nNum;
    logic              rdValid, rdLast, wrValid, busy, done;
    logic [IN_AW-1:0]  rdInAddr;
    logic [W_AW-1:0]   rdWAddr;
    logic [OUT_AW-1:0] wrAddr;
`ifdef MM_PERF_CNT_EN
    logic [31:0]       perfCycles;
`endif

    int assertCount = 0;
    int failCount   = 0;

    int rdIn[$], rdW[$], rdL[$], rdCyc[$], wrA[$], wrCyc[$], busyLog[$];
    int doneCnt, doneCyc;

    always #5 clk = ~clk;

    mm_addr_seq #(
        .IN_AW(IN_AW), .W_AW(W_AW), .OUT_AW(OUT_AW),
        .CI_W(CI_W), .N_W(N_W), .OUT_LAT(OUT_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_base(inBase), .w_base(wBase), .out_base(outBase),
        .ci_num(ciNum), .co_num(coNum), .n_num(nNum), .stall(stall),
        .rd_valid(rdValid), .rd_in_addr(rdInAddr), .rd_w_addr(rdWAddr), .rd_last(rdLast),
        .wr_valid(wrValid), .wr_addr(wrAddr), .busy(busy), .done(done)
`ifdef MM_PERF_CNT_EN
        , .perf_cycles(perfCycles)
`endif
    );

    // Pulses start, then logs every observed cycle (cycle 1 = first falling edge after start is taken).
    task automatic run_job(input int cycles, input int stallFrom, input int stallLen, input int restartAt);
        rdIn.delete(); rdW.delete(); rdL.delete(); rdCyc.delete();
        wrA.delete(); wrCyc.delete(); busyLog.delete();
        doneCnt = 0;
        doneCyc = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= cycles; c++) begin
            if (rdValid) begin
                rdIn.push_back(int'(rdInAddr));
                rdW.push_back(int'(rdWAddr));
                rdL.push_back(int'(rdLast));
                rdCyc.push_back(c);
            end
            if (wrValid) begin
                wrA.push_back(int'(wrAddr));
                wrCyc.push_back(c);
            end
            if (done) begin
                doneCnt++;
                doneCyc = c;
            end
            busyLog.push_back(int'(busy));
            stall = (c + 1 >= stallFrom) && (c + 1 < stallFrom + stallLen);
            if (c == restartAt) begin
                start  = 1'b1;
                ciNum  = 8'd5;
                nNum   = 16'd1;
                inBase = 11'd100;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        assertCount++;
        if ({rdValid, rdLast, wrValid, busy, done} !== 5'b0 || rdInAddr !== '0 || rdWAddr !== '0 || wrAddr !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got valid/last/wr/busy/done=%b%b%b%b%b addrs=%0d/%0d/%0d, expected all 0",
                     rdValid, rdLast, wrValid, busy, done, rdInAddr, rdWAddr, wrAddr);
        end
`ifdef MM_PERF_CNT_EN
        assertCount++;
        if (perfCycles !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL reset_perf: got %0d, expected 0", perfCycles);
        end
`endif
    endtask

    task automatic test_basic();
        int expIn[8]   = '{0, 1, 0, 1, 2, 3, 2, 3};
        int expW[8]    = '{0, 1, 2, 3, 0, 1, 2, 3};
        int expLast[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        ciNum = 8'd2; coNum = 8'd2; nNum = 16'd2;
        inBase = '0; wBase = '0; outBase = '0;
        run_job(20, 0, 0, 4);
        assertCount++;
        if (rdIn.size() != 8) begin
            failCount++;
            $display("[TB] FAIL basic_rd_count: got %0d, expected 8", rdIn.size());
        end
        for (int i = 0; i < 8 && i < rdIn.size(); i++) begin
            assertCount++;
            if (rdIn[i] != expIn[i] || rdW[i] != expW[i] || rdL[i] != expLast[i] || rdCyc[i] != i + 1) begin
                failCount++;
                $display("[TB] FAIL basic_rd_beat%0d: got in=%0d w=%0d last=%0d cyc=%0d, expected in=%0d w=%0d last=%0d cyc=%0d",
                         i, rdIn[i], rdW[i], rdL[i], rdCyc[i], expIn[i], expW[i], expLast[i], i + 1);
            end
        end
        assertCount++;
        if (wrA.size() != 4) begin
            failCount++;
            $display("[TB] FAIL basic_wr_count: got %0d, expected 4", wrA.size());
        end
        for (int i = 0; i < 4 && i < wrA.size(); i++) begin
            assertCount++;
            if (wrA[i] != i || wrCyc[i] != 2 * i + 2 + OUT_LAT) begin
                failCount++;
                $display("[TB] FAIL basic_wr%0d: got addr=%0d cyc=%0d, expected addr=%0d cyc=%0d",
                         i, wrA[i], wrCyc[i], i, 2 * i + 2 + OUT_LAT);
            end
        end
        assertCount++;
        if (doneCnt != 1 || doneCyc != 13) begin
            failCount++;
            $display("[TB] FAIL basic_done: got count=%0d cyc=%0d, expected count=1 cyc=13", doneCnt, doneCyc);
        end
        assertCount++;
        if (busyLog[0] != 1 || busyLog[12] != 1 || busyLog[13] != 0) begin
            failCount++;
            $display("[TB] FAIL basic_busy: got c1=%0d c13=%0d c14=%0d, expected 1 1 0", busyLog[0], busyLog[12], busyLog[13]);
        end
    endtask

    task automatic test_stall();
        int expIn[6]  = '{0, 1, 2, 3, 4, 5};
        int expW[6]   = '{0, 1, 2, 0, 1, 2};
        int expCyc[6] = '{1, 2, 6, 7, 8, 9};
        ciNum = 8'd3; coNum = 8'd1; nNum = 16'd2;
        inBase = '0; wBase = '0; outBase = 11'd5;
        run_job(20, 3, 3, -1);
        assertCount++;
        if (rdIn.size() != 6) begin
            failCount++;
            $display("[TB] FAIL stall_rd_count: got %0d, expected 6", rdIn.size());
        end
        for (int i = 0; i < 6 && i < rdIn.size(); i++) begin
            assertCount++;
            if (rdIn[i] != expIn[i] || rdW[i] != expW[i] || rdL[i] != int'(i % 3 == 2) || rdCyc[i] != expCyc[i]) begin
                failCount++;
                $display("[TB] FAIL stall_rd_beat%0d: got in=%0d w=%0d last=%0d cyc=%0d, expected in=%0d w=%0d last=%0d cyc=%0d",
                         i, rdIn[i], rdW[i], rdL[i], rdCyc[i], expIn[i], expW[i], int'(i % 3 == 2), expCyc[i]);
            end
        end
        assertCount++;
        if (wrA.size() != 2 || wrA[0] != 5 || wrA[1] != 6 || wrCyc[0] != 10 || wrCyc[1] != 13) begin
            failCount++;
            $display("[TB] FAIL stall_wr: got count=%0d, expected addrs 5,6 at cycles 10,13", wrA.size());
        end
        assertCount++;
        if (doneCnt != 1 || doneCyc != 14) begin
            failCount++;
            $display("[TB] FAIL stall_done: got count=%0d cyc=%0d, expected count=1 cyc=14", doneCnt, doneCyc);
        end
`ifdef MM_PERF_CNT_EN
        assertCount++;
        if (perfCycles !== 32'd3) begin
            failCount++;
            $display("[TB] FAIL stall_perf: got %0d, expected 3", perfCycles);
        end
`endif
    endtask

    task automatic test_wrap();
        int expIn[4] = '{2046, 2047, 0, 1};
        int expW[4]  = '{8190, 8191, 0, 1};
        ciNum = 8'd4; coNum = 8'd1; nNum = 16'd1;
        inBase = 11'd2046; wBase = 13'd8190; outBase = 11'd2047;
        run_job(12, 0, 0, -1);
        assertCount++;
        if (rdIn.size() != 4) begin
            failCount++;
            $display("[TB] FAIL wrap_rd_count: got %0d, expected 4", rdIn.size());
        end
        for (int i = 0; i < 4 && i < rdIn.size(); i++) begin
            assertCount++;
            if (rdIn[i] != expIn[i] || rdW[i] != expW[i] || rdL[i] != int'(i == 3)) begin
                failCount++;
                $display("[TB] FAIL wrap_rd_beat%0d: got in=%0d w=%0d last=%0d, expected in=%0d w=%0d last=%0d",
                         i, rdIn[i], rdW[i], rdL[i], expIn[i], expW[i], int'(i == 3));
            end
        end
        assertCount++;
        if (wrA.size() != 1 || wrA[0] != 2047 || wrCyc[0] != 8 || doneCyc != 9) begin
            failCount++;
            $display("[TB] FAIL wrap_wr: got count=%0d done=%0d, expected addr 2047 at cycle 8, done cycle 9", wrA.size(), doneCyc);
        end
    endtask

    task automatic test_zero_cfg();
        ciNum = 8'd3; coNum = 8'd2; nNum = 16'd0;
        inBase = '0; wBase = '0; outBase = '0;
        run_job(8, 0, 0, -1);
        assertCount++;
        if (rdIn.size() != 0 || wrA.size() != 0) begin
            failCount++;
            $display("[TB] FAIL zero_no_beats: got rd=%0d wr=%0d, expected 0 0", rdIn.size(), wrA.size());
        end
        assertCount++;
        if (doneCnt != 1 || doneCyc != 1 || busyLog[1] != 0) begin
            failCount++;
            $display("[TB] FAIL zero_done: got count=%0d cyc=%0d busy2=%0d, expected 1 1 0", doneCnt, doneCyc, busyLog[1]);
        end
    endtask

    task automatic test_reset_midjob();
        int sawDone = 0;
        ciNum = 8'd2; coNum = 8'd2; nNum = 16'd2;
        inBase = 11'd7; wBase = 13'd9; outBase = 11'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        assertCount++;
        if (rdValid !== 1'b1 || busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midjob_running: got valid=%b busy=%b, expected 1 1", rdValid, busy);
        end
        rst = 1'b1;
        #1;
        assertCount++;
        if ({rdValid, rdLast, wrValid, busy, done} !== 5'b0 || rdInAddr !== '0 || rdWAddr !== '0 || wrAddr !== '0) begin
            failCount++;
            $display("[TB] FAIL midjob_reset_outputs: got valid/last/wr/busy/done=%b%b%b%b%b, expected 00000",
                     rdValid, rdLast, wrValid, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done || rdValid || wrValid) sawDone++;
            @(negedge clk);
        end
        assertCount++;
        if (sawDone != 0) begin
            failCount++;
            $display("[TB] FAIL midjob_aborted: got %0d active cycles, expected 0", sawDone);
        end
        ciNum = 8'd1; coNum = 8'd2; nNum = 16'd1;
        inBase = 11'd10; wBase = 13'd20; outBase = 11'd30;
        run_job(12, 0, 0, -1);
        assertCount++;
        if (rdIn.size() != 2 || rdIn[0] != 10 || rdIn[1] != 10 || rdW[0] != 20 || rdW[1] != 21
            || rdL[0] != 1 || rdL[1] != 1) begin
            failCount++;
            $display("[TB] FAIL ci1_rd: got count=%0d, expected in 10,10 w 20,21 last 1,1", rdIn.size());
        end
        assertCount++;
        if (wrA.size() != 2 || wrA[0] != 30 || wrA[1] != 31 || wrCyc[0] != 5 || wrCyc[1] != 6) begin
            failCount++;
            $display("[TB] FAIL ci1_wr_back_to_back: got count=%0d, expected addrs 30,31 at cycles 5,6", wrA.size());
        end
        assertCount++;
        if (doneCnt != 1 || doneCyc != 7) begin
            failCount++;
            $display("[TB] FAIL ci1_done: got count=%0d cyc=%0d, expected 1 7", doneCnt, doneCyc);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        inBase = '0; wBase = '0; outBase = '0;
        ciNum = '0; coNum = '0; nNum = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] basic job");
        test_basic();
        $display("[TB] stall job");
        test_stall();
        $display("[TB] address wrap job");
        test_wrap();
        $display("[TB] zero-size job");
        test_zero_cfg();
        $display("[TB] reset during run");
        test_reset_midjob();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
